// File: rtl/uart_tx_engine.sv
// uart_tx_engine
// Transmit sequencer for the UART. It pops 9-bit words from the show-ahead TX
// FIFO and serialises each one on txd as follows:
//   - a start bit;
//   - 8 or 9 data bits, LSB first (the last one optionally replaced by parity);
//   - 0.5 / 1 / 1.5 / 2 stop bits.
// Bit timing comes from the fractional divisor {br_mantissa, br_fraction}.
//
// Ports
//   clk, rst_n         block clock, asynchronous active-low reset
//   cfg_te             transmit enable
//   cfg_wdlen          0 = 8 data bits, 1 = 9 data bits (parity included)
//   cfg_pce, cfg_ps    parity enable, parity select (0 = even, 1 = odd)
//   cfg_stoplen        00 = 1, 01 = 0.5, 10 = 2, 11 = 1.5 stop bits
//   br_mantissa/frac   bit period in clk cycles = {mantissa, fraction}, min 16
//   fifo_rd_valid/data TX FIFO head (show-ahead)
//   fifo_rd_en         one-cycle pop strobe
//   txd                registered serial output, idles high
//   tx_busy            sequencer is not idle
//   sr_tc              transmission complete status
//   tx_frame_done      one-cycle pulse in the last stop cycle of every frame
`timescale 1ns/1ps

module uart_tx_engine #(
  parameter int DIV_WD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_te,
  input  logic        cfg_wdlen,
  input  logic        cfg_pce,
  input  logic        cfg_ps,
  input  logic [1:0]  cfg_stoplen,
  input  logic [11:0] br_mantissa,
  input  logic [3:0]  br_fraction,
  input  logic        fifo_rd_valid,
  input  logic [8:0]  fifo_rd_data,
  output logic        fifo_rd_en,
  output logic        txd,
  output logic        tx_busy,
  output logic        sr_tc,
  output logic        tx_frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Two extra bits so the longest stop period (4 half-bits) fits.
  localparam int                CNT_W   = DIV_WD + 2;
  localparam logic [DIV_WD-1:0] DIV_MIN = DIV_WD'(16);

  // Builds the on-wire data word.
  // - Drops bit 8 for 8-bit frames.
  // - Substitutes the parity bit into the last data position.
  // - The XOR with ps turns even parity into odd parity.
  function automatic logic [8:0] frame_word(input logic [8:0] d,
                                            input logic       wdlen,
                                            input logic       pce,
                                            input logic       ps);
    logic [8:0] w;
    w = wdlen ? d : {1'b0, d[7:0]};
    if (pce) begin
      if (wdlen) w[8] = (^d[7:0]) ^ ps;
      else       w[7] = (^d[6:0]) ^ ps;
    end
    return w;
  endfunction

  // Stop period in clk cycles: 1/2/3/4 half-bit periods for stoplen 01/00/11/10.
  function automatic logic [CNT_W-1:0] stop_cycles(input logic [1:0]        sl,
                                                   input logic [DIV_WD-1:0] d);
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] res;
    half = CNT_W'(d >> 1);
    unique case (sl)
      2'b01:   res = half;
      2'b00:   res = half << 1;
      2'b11:   res = (half << 1) + half;
      default: res = half << 2;
    endcase
    return res;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        bit_q, bit_d;
  logic [8:0]        shift_q, shift_d;
  logic              wdlen_q, wdlen_d;
  logic [DIV_WD-1:0] div_q, div_d;
  logic [CNT_W-1:0]  stop_q, stop_d;
  logic              txd_q, txd_d;
  logic              tc_q, tc_d;
  logic              run_q;

  logic [DIV_WD-1:0] div_raw;
  logic [DIV_WD-1:0] div_clamped;
  logic [CNT_W-1:0]  limit;
  logic [3:0]        last_bit;
  logic              expire;
  logic              stop_end;
  logic              launch;

  assign div_raw     = DIV_WD'({br_mantissa, br_fraction});
  assign div_clamped = (div_raw < DIV_MIN) ? DIV_MIN : div_raw;

  // One counter serves every state; only its terminal count changes.
  assign limit    = (state_q == S_STOP) ? stop_q : CNT_W'(div_q);
  assign expire   = (state_q != S_IDLE) && (cnt_q == limit - CNT_W'(1));
  assign stop_end = (state_q == S_STOP) && expire;
  assign last_bit = wdlen_q ? 4'd8 : 4'd7;

  // A launch happens either from IDLE or straight out of the final stop cycle,
  // which gives back-to-back frames without an idle gap. run_q keeps the pop
  // strobe quiet while reset is applied and for the first cycle after it.
  assign launch = run_q && cfg_te && fifo_rd_valid &&
                  ((state_q == S_IDLE) || stop_end);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    wdlen_d = wdlen_q;
    div_d   = div_q;
    stop_d  = stop_q;
    txd_d   = txd_q;
    tc_d    = tc_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
      end
      S_START: begin
        if (expire) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = 4'd0;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (expire) begin
          cnt_d = '0;
          if (bit_q == last_bit) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 4'd1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin // S_STOP
        if (expire) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          tc_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    // Launch overrides the stop-expiry path; frame controls are frozen here.
    if (launch) begin
      state_d = S_START;
      cnt_d   = '0;
      bit_d   = 4'd0;
      shift_d = frame_word(fifo_rd_data, cfg_wdlen, cfg_pce, cfg_ps);
      wdlen_d = cfg_wdlen;
      div_d   = div_clamped;
      stop_d  = stop_cycles(cfg_stoplen, div_clamped);
      txd_d   = 1'b0;
      tc_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 4'd0;
      shift_q <= 9'd0;
      wdlen_q <= 1'b0;
      div_q   <= '0;
      stop_q  <= '0;
      txd_q   <= 1'b1;
      tc_q    <= 1'b1;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      wdlen_q <= wdlen_d;
      div_q   <= div_d;
      stop_q  <= stop_d;
      txd_q   <= txd_d;
      tc_q    <= tc_d;
      run_q   <= 1'b1;
    end
  end

  assign fifo_rd_en    = launch;
  assign txd           = txd_q;
  assign tx_busy       = (state_q != S_IDLE);
  assign sr_tc         = tc_q;
  assign tx_frame_done = stop_end;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Testbench for uart_tx_engine.
// - A queue-based FIFO model feeds the DUT.
// - Each transmitted word has a hand-computed expected frame pushed into a
//   scoreboard.
// - A monitor records txd from the pop onward. At every tx_frame_done it checks
//   the frame length, the mid-bit values, the start-bit edges and the stop
//   high time against the scoreboard entry.
`timescale 1ns/1ps

module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_te, cfg_wdlen, cfg_pce, cfg_ps;
  logic [1:0] cfg_stoplen;
  logic [11:0] br_mantissa;
  logic [3:0]  br_fraction;
  logic       fifo_rd_valid = 1'b0;
  logic [8:0] fifo_rd_data  = 9'h000;
  logic       fifo_rd_en, txd, tx_busy, sr_tc, tx_frame_done;

  uart_tx_engine #(.DIV_WD(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_te        (cfg_te),
    .cfg_wdlen     (cfg_wdlen),
    .cfg_pce       (cfg_pce),
    .cfg_ps        (cfg_ps),
    .cfg_stoplen   (cfg_stoplen),
    .br_mantissa   (br_mantissa),
    .br_fraction   (br_fraction),
    .fifo_rd_valid (fifo_rd_valid),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_en    (fifo_rd_en),
    .txd           (txd),
    .tx_busy       (tx_busy),
    .sr_tc         (sr_tc),
    .tx_frame_done (tx_frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bits;   // bit k = expected txd level of bit slot k (slot 0 = start)
    int nb;     // start + data slots
    int div;    // bit period in cycles
    int stop;   // stop high time in cycles
  } exp_t;

  exp_t       sb[$];
  logic [8:0] fq[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         n_pops = 0;
  int         cyc = 0;
  logic       rec [0:1023];
  logic       mon_active = 1'b0;
  int         mon_t0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Show-ahead FIFO model.
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) void'(fq.pop_front());
    fifo_rd_valid <= (fq.size() > 0);
    fifo_rd_data  <= (fq.size() > 0) ? fq[0] : 9'h000;
  end

  // Monitor / scoreboard consumer.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   len, got, ones, edges;
    if (!rst_n) begin
      mon_active = 1'b0;
    end else begin
      if (mon_active && (cyc - mon_t0 - 1) < 1024) rec[cyc - mon_t0 - 1] = txd;
      if (tx_frame_done) begin
        if (!mon_active || sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL frame_unexpected: done pulse with no expected frame (cycle %0d)", cyc);
        end else begin
          e   = sb.pop_front();
          len = cyc - mon_t0;
          check("frame_len", len, e.div * e.nb + e.stop);
          got = 0;
          for (int k = 0; k < e.nb; k++)
            if (rec[k * e.div + e.div / 2] === 1'b1) got |= (1 << k);
          check("frame_bits", got, e.bits);
          edges = int'(rec[0]) + int'(rec[e.div - 1]);
          check("start_edges", edges, 0);
          ones = 0;
          for (int i = e.nb * e.div; i < len && i < 1024; i++)
            if (rec[i] === 1'b1) ones++;
          check("stop_high", ones, e.stop);
        end
        mon_active = 1'b0;
      end
      if (fifo_rd_en) begin
        check("pop_while_valid", int'(fifo_rd_valid), 1);
        n_pops++;
        mon_active = 1'b1;
        mon_t0     = cyc;
      end
    end
  end

  task automatic expect_frame(input int bits, input int nb, input int div, input int stop);
    exp_t e;
    e.bits = bits;
    e.nb   = nb;
    e.div  = div;
    e.stop = stop;
    sb.push_back(e);
  endtask

  task automatic send(input logic [8:0] w, input int bits, input int nb,
                      input int div, input int stop);
    expect_frame(bits, nb, div, stop);
    fq.push_back(w);
  endtask

  task automatic wait_done(input int budget, output int at);
    int n;
    n  = 0;
    at = -1;
    while (n < budget) begin
      @(negedge clk);
      if (tx_frame_done) begin
        at = cyc;
        break;
      end
      n++;
    end
    if (at < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL done_timeout: no tx_frame_done within %0d cycles", budget);
    end
  endtask

  task automatic set_cfg(input logic te, input logic wl, input logic pce, input logic ps,
                         input logic [1:0] sl, input logic [11:0] m, input logic [3:0] f);
    cfg_te      = te;
    cfg_wdlen   = wl;
    cfg_pce     = pce;
    cfg_ps      = ps;
    cfg_stoplen = sl;
    br_mantissa = m;
    br_fraction = f;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int t, p0, dones, viol, n;
    int sl_tab[4];
    int st_tab[4];
    sl_tab = '{1, 0, 3, 2};
    st_tab = '{16, 32, 48, 64};

    rst_n = 1'b0;
    set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 12'd1, 4'd0);
    repeat (3) @(negedge clk);
    check("rst_txd", int'(txd), 1);
    check("rst_tc", int'(sr_tc), 1);
    check("rst_rd_en", int'(fifo_rd_en), 0);
    check("rst_busy", int'(tx_busy), 0);
    check("rst_done", int'(tx_frame_done), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_pop", n_pops, 0);

    // 8N1, DIV = 16, 0x55 -> slots 0,1,0,1,0,1,0,1,0 ; stop 16 cycles
    send(9'h055, 'h0AA, 9, 16, 16);
    wait_done(400, t);
    check("tc_at_done", int'(sr_tc), 0);
    @(negedge clk);
    check("tc_after_8n1", int'(sr_tc), 1);
    check("busy_after_8n1", int'(tx_busy), 0);

    // 9-bit odd parity, 0x0A5: four ones -> parity 1 in slot 9
    set_cfg(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 12'd1, 4'd0);
    send(9'h0A5, 'h34A, 10, 16, 16);
    wait_done(400, t);
    @(negedge clk);

    // 8-bit even parity, 0x183: bit 8 ignored, bits 0..6 have two ones -> byte 0x03
    set_cfg(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 12'd1, 4'd0);
    send(9'h183, 'h006, 9, 16, 16);
    wait_done(400, t);
    @(negedge clk);

    // 8-bit odd parity, same word -> byte 0x83
    set_cfg(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 12'd1, 4'd0);
    send(9'h183, 'h106, 9, 16, 16);
    wait_done(400, t);
    @(negedge clk);

    // Stop lengths at DIV = 32
    for (int i = 0; i < 4; i++) begin
      set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 2'(sl_tab[i]), 12'd2, 4'd0);
      send(9'h0F0, 'h1E0, 9, 32, st_tab[i]);
      wait_done(700, t);
      @(negedge clk);
    end

    // Back-to-back: three words queued together
    set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 12'd1, 4'd0);
    p0 = n_pops;
    send(9'h001, 'h002, 9, 16, 16);
    send(9'h080, 'h100, 9, 16, 16);
    send(9'h0FF, 'h1FE, 9, 16, 16);
    dones = 0;
    viol  = 0;
    n     = 0;
    t     = 0;
    while (dones < 3 && n < 1000) begin
      @(negedge clk);
      n++;
      if (t != 0 && (!tx_busy || sr_tc)) viol++;
      if (fifo_rd_en) t = 1;
      if (tx_frame_done) dones++;
    end
    check("b2b_dones", dones, 3);
    check("b2b_pops", n_pops - p0, 3);
    check("b2b_gap_or_tc", viol, 0);
    @(negedge clk);
    check("b2b_tc_end", int'(sr_tc), 1);

    // TE drop mid-DATA with two more words queued
    p0 = n_pops;
    send(9'h03C, 'h078, 9, 16, 16);
    fq.push_back(9'h011);
    fq.push_back(9'h022);
    repeat (60) @(negedge clk);
    check("te_busy_mid", int'(tx_busy), 1);
    cfg_te = 1'b0;
    wait_done(400, t);
    @(negedge clk);
    check("te_tc", int'(sr_tc), 1);
    repeat (4) @(negedge clk);
    check("te_pops", n_pops - p0, 1);
    check("te_fifo_left", fq.size(), 2);
    check("te_idle", int'(tx_busy), 0);
    fq.delete();
    repeat (2) @(negedge clk);

    // Divisor clamp: DIV = 5 behaves as 16
    set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 12'd0, 4'd5);
    send(9'h0AA, 'h154, 9, 16, 16);
    wait_done(400, t);
    @(negedge clk);

    // Async reset mid-frame, then the next queued word launches cleanly
    set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 12'd1, 4'd0);
    fq.push_back(9'h000);
    fq.push_back(9'h0C3);
    repeat (40) @(negedge clk);
    check("ar_txd_low_before", int'(txd), 0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_txd", int'(txd), 1);
    check("ar_busy", int'(tx_busy), 0);
    check("ar_tc", int'(sr_tc), 1);
    check("ar_rd_en", int'(fifo_rd_en), 0);
    @(negedge clk);
    @(negedge clk);
    check("ar_rd_en_held", int'(fifo_rd_en), 0);
    expect_frame('h186, 9, 16, 16);
    rst_n = 1'b1;
    wait_done(400, t);
    @(negedge clk);
    check("ar_tc_after", int'(sr_tc), 1);

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("fifo_empty", fq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Transmit sequencer for the UART. It pops 9-bit words from the TX FIFO and drives the serial `txd` line: start bit, data bits LSB-first, optional parity, then 0.5/1/1.5/2 stop bits. Bit timing comes from the fractional baud divisor programmed in BRR. It consumes the CR0 frame controls and BRR fields from the APB register block, and returns TC status plus a per-frame pulse to the status/interrupt logic.

## Interface
- `DIV_WD`, default 16: width of the bit-period counter; must equal mantissa width plus fraction width.
- `clk`  in  1  block clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cfg_te`  in  1  TX enable (CR0.TE).
- `cfg_wdlen`  in  1  frame data length: 0 = 8 bits, 1 = 9 bits, parity included.
- `cfg_pce`  in  1  parity enable.
- `cfg_ps`  in  1  parity select: 0 = even, 1 = odd.
- `cfg_stoplen`  in  2  stop length: 00 = 1, 01 = 0.5, 10 = 2, 11 = 1.5 bits.
- `br_mantissa`  in  12  BRR mantissa.
- `br_fraction`  in  4  BRR fraction.
- `fifo_rd_valid`  in  1  TX FIFO not empty (show-ahead).
- `fifo_rd_data`  in  9  TX FIFO head word.
- `fifo_rd_en`  out  1  pop strobe, one cycle.
- `txd`  out  1  serial output, registered.
- `tx_busy`  out  1  state is not IDLE.
- `sr_tc`  out  1  transmission complete status.
- `tx_frame_done`  out  1  one-cycle pulse at the end of each stop period.

## Operation
- **Bit period**
  - `DIV = {br_mantissa, br_fraction}`, in clk cycles per bit (oversample-16 form).
  - `DIV < 16` is clamped to 16.
  - Half-bit period is `DIV >> 1`.
- **Frame parameters**
  - `cfg_*` and `DIV` are latched at frame launch.
  - Changes during a frame take effect at the next frame.
- **States: IDLE → START → DATA → STOP → IDLE/START**
  - **IDLE:** if `cfg_te && fifo_rd_valid`:
    - pulse `fifo_rd_en`;
    - capture `fifo_rd_data` into the shift register;
    - latch config;
    - clear `sr_tc`;
    - go to START.
  - **START:** `txd = 0` for DIV cycles, then go to DATA.
  - **DATA:** N bits, LSB first, DIV cycles each.
    - N = 8 (`wdlen = 0`) or 9 (`wdlen = 1`).
    - If `pce = 1`, bit N-1 is replaced by parity computed over bits 0..N-2.
    - Even parity: the total count of ones over data plus parity is even. Odd parity: that count is odd.
    - Go to STOP after bit N-1.
  - **STOP:** `txd = 1` for 1/2/3/4 half-bit periods, selected by stoplen 01/00/11/10. On expiry:
    - pulse `tx_frame_done`;
    - if `cfg_te && fifo_rd_valid`: pop and launch the next frame directly, entering START the next cycle (back-to-back, no idle gap);
    - otherwise set `sr_tc = 1` and go to IDLE.
- **`cfg_te` deassert mid-frame:** the current frame completes, including stop bits. No further pops.
- **FIFO empty:** no pop and no `txd` activity. `fifo_rd_en` is never asserted while `fifo_rd_valid = 0`.
- **Unused upper data bits:** `fifo_rd_data[8]` is ignored when `wdlen = 0`.

## Timing
- **Reset values:**
  - `txd = 1`, `sr_tc = 1`
  - `fifo_rd_en = 0`, `tx_busy = 0`, `tx_frame_done = 0`
  - state IDLE, counters 0
- **Launch latency:** pop in cycle T (IDLE); `txd` falls in cycle T+1.
- **Frame duration:**
  - The start bit spans cycles T+1 .. T+DIV.
  - Total frame length in cycles = DIV·(1+N) + stop half-bits·(DIV>>1).
- **Done pulse:** `tx_frame_done` is asserted in the last stop cycle.
- **Back-to-back frames:** the next pop occurs in that same last stop cycle, and the next start bit begins the following cycle.
- **`sr_tc`:** rises in the cycle after the last stop cycle when no frame follows. It falls in the cycle after the launching pop.
- **Simultaneous events:** if `fifo_rd_valid` rises in the final stop cycle, it is honored as back-to-back and `sr_tc` stays 0.
- **Reset mid-frame:** all outputs return to their reset values immediately (async); `txd` goes high.

## Test plan
- **8N1:** mantissa = 1, fraction = 0 (DIV = 16), stoplen = 00, pce = 0, push 0x055.
  - `txd` = 0, 1,0,1,0,1,0,1,0, 1, with each bit 16 cycles (160 total).
  - `tx_frame_done` pulses at cycle 160 after launch; `sr_tc` = 1 the next cycle.
- **9-bit odd parity:** wdlen = 1, pce = 1, ps = 1, push 0x0A5.
  - Data bits 0..7 = 0xA5 (four ones), so parity = 1.
  - Frame = 0, 1,0,1,0,0,1,0,1, 1, 1.
- **Stop lengths, DIV = 32:** stoplen 01/00/11/10 gives stop high time of 16/32/48/64 cycles, measured to `tx_frame_done`.
- **Back-to-back:** preload 3 words.
  - Exactly 3 `fifo_rd_en` pulses.
  - No idle cycle between a stop bit and the following start bit.
  - `sr_tc` stays 0 until after the third frame.
- **TE drop and clamp:**
  - Deassert `cfg_te` mid-DATA with 2 words queued: the current frame finishes, no pop occurs, and `sr_tc` = 1.
  - Set DIV = 5: the bit period measures 16 cycles.
- **Async reset:** assert `rst_n = 0` mid-frame.
  - `txd` = 1, `tx_busy` = 0 and `sr_tc` = 1 immediately.
  - After release, the next queued word launches a clean frame.
